// File: rtl/start_bit_pkg.sv
// start_bit_pkg: shared types and default parameters for the start bit validator.
//   sbv_state_t     - per-channel FSM state (IDLE / VERIFY / BUSY)
//   DEF_NUM_CH      - default number of serial channels
//   DEF_SYNC_STAGES - default synchronizer depth
//   DEF_CNT_W       - default half-bit counter width
package start_bit_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_BUSY   = 2'd2
  } sbv_state_t;

endpackage

// File: rtl/start_bit_channel.sv
// start_bit_channel: one serial line's start bit detector.
// Synchronizes the line, finds falling edges, checks the line is still low
// half a bit later, and reports either a validated start or a glitch.
// Ports:
//   clk, n_rst          - clock, async active-low reset
//   serial_in           - asynchronous serial line, idle high
//   enable              - detection enable; low forces IDLE
//   half_bit_cnt        - clocks from detected edge to mid-bit check (0 acts as 1)
//   clear_busy          - re-arm strobe, only honoured in BUSY
//   new_packet_detected - one-cycle pulse, start bit validated
//   false_start         - one-cycle pulse, start bit rejected
//   busy                - channel owns a validated packet
module start_bit_channel
  import start_bit_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             serial_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_bit_cnt,
  input  logic             clear_busy,
  output logic             new_packet_detected,
  output logic             false_start,
  output logic             busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   prev_q;
  logic                   armed_q;
  logic                   sample;
  logic                   fall;

  sbv_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hb_eff;
  logic             npd_q, npd_d;
  logic             fs_q, fs_d;

  assign sample = sync_q[SYNC_STAGES-1];

  // The sync chain resets to 1, so a line held low through reset would look
  // like a fresh edge. vld_pipe tracks when the chain carries real pin data;
  // edges only count once a genuine high has been seen since reset.
  assign fall = armed_q & prev_q & ~sample;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q   <= '1;
      vld_pipe <= '0;
      prev_q   <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], serial_in};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      prev_q   <= sample;
      armed_q  <= armed_q | (vld_pipe[SYNC_STAGES-1] & sample);
    end
  end

  assign hb_eff = (half_bit_cnt == '0) ? CNT_W'(1) : half_bit_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      npd_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npd_q   <= npd_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    npd_d   = 1'b0;
    fs_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d = ST_VERIFY;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_VERIFY: begin
          // Glitch check wins over terminal count.
          if (sample) begin
            state_d = ST_IDLE;
            fs_d    = 1'b1;
          end else if (cnt_q >= hb_eff) begin
            // >= rather than == so a live drop of half_bit_cnt below the
            // running count terminates instead of wrapping the counter.
            state_d = ST_BUSY;
            npd_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (clear_busy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign new_packet_detected = npd_q;
  assign false_start         = fs_q;
  assign busy                = (state_q == ST_BUSY);

endmodule

// File: rtl/start_bit_validator.sv
// start_bit_validator: NUM_CH independent start bit detectors sharing one
// half-bit count.
// Ports:
//   clk, n_rst          - clock, async active-low reset
//   serial_in[NUM_CH]   - asynchronous serial lines, idle high
//   enable[NUM_CH]      - per-channel detection enable
//   half_bit_cnt        - shared edge-to-mid-bit distance in clocks
//   clear_busy[NUM_CH]  - per-channel re-arm strobe
//   new_packet_detected - per-channel validated-start pulse
//   false_start         - per-channel glitch pulse
//   busy                - per-channel packet-owned flag
module start_bit_validator
  import start_bit_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] serial_in,
  input  logic [NUM_CH-1:0] enable,
  input  logic [CNT_W-1:0]  half_bit_cnt,
  input  logic [NUM_CH-1:0] clear_busy,
  output logic [NUM_CH-1:0] new_packet_detected,
  output logic [NUM_CH-1:0] false_start,
  output logic [NUM_CH-1:0] busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    start_bit_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk                 (clk),
      .n_rst               (n_rst),
      .serial_in           (serial_in[g]),
      .enable              (enable[g]),
      .half_bit_cnt        (half_bit_cnt),
      .clear_busy          (clear_busy[g]),
      .new_packet_detected (new_packet_detected[g]),
      .false_start         (false_start[g]),
      .busy                (busy[g])
    );
  end

endmodule

// File: tb/tb_start_bit_validator.sv
// Scoreboard bench: stimulus pushes expected pulse vectors with their
// expected cycle; a negedge monitor pops and compares whenever a pulse shows.
module tb_start_bit_validator;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] serial_in;
  logic [3:0] enable;
  logic [7:0] half_bit_cnt;
  logic [3:0] clear_busy;
  logic [3:0] npd;
  logic [3:0] fs;
  logic [3:0] busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] npd;
    logic [3:0] fs;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  start_bit_validator #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .serial_in           (serial_in),
    .enable              (enable),
    .half_bit_cnt        (half_bit_cnt),
    .clear_busy          (clear_busy),
    .new_packet_detected (npd),
    .false_start         (fs),
    .busy                (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected pulse dly cycles after the current (post-edge) cycle.
  task automatic expect_evt(input logic [3:0] e_npd, input logic [3:0] e_fs, input int dly);
    exp_t e;
    e.npd = e_npd;
    e.fs  = e_fs;
    e.cyc = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic pulse_clear(input logic [3:0] m);
    clear_busy = m;
    tick(1);
    clear_busy = '0;
  endtask

  // Monitor: flags overdue expectations, then checks any presented pulse.
  always @(negedge clk) begin
    if (n_rst) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none expected npd=%0h fs=%0h at cycle %0d",
                 exp_q[0].npd, exp_q[0].fs, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if ((npd | fs) != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got npd=%0h fs=%0h expected none (cycle %0d)",
                   npd, fs, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (npd !== e.npd || fs !== e.fs || cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
            errors++;
            $display("FAIL pulse: got npd=%0h fs=%0h cyc=%0d expected npd=%0h fs=%0h cyc=%0d",
                     npd, fs, cyc, e.npd, e.fs, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    n_rst        = 1'b0;
    serial_in    = 4'hF;
    enable       = 4'hF;
    half_bit_cnt = 8'd8;
    clear_busy   = '0;
    tick(3);
    chk("rst_npd", 32'(npd), 32'h0);
    chk("rst_fs", 32'(fs), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    n_rst = 1'b1;
    tick(10);

    // Valid start on ch0: 2 sync + 8 + 1 = 11 cycles.
    serial_in[0] = 1'b0;
    expect_evt(4'h1, 4'h0, 11);
    tick(20);
    chk("ch0_busy", 32'(busy), 32'h1);

    // 3-cycle glitch on ch1.
    serial_in[1] = 1'b0;
    expect_evt(4'h0, 4'h2, 6);
    tick(3);
    serial_in[1] = 1'b1;
    tick(10);
    chk("ch1_glitch_idle", 32'(busy), 32'h1);

    // Edges while ch0 busy are ignored; clear re-arms.
    for (int i = 0; i < 3; i++) begin
      serial_in[0] = 1'b1; tick(4);
      serial_in[0] = 1'b0; tick(4);
    end
    serial_in[0] = 1'b1;
    tick(5);
    chk("ch0_still_busy", 32'(busy), 32'h1);
    pulse_clear(4'h1);
    chk("ch0_cleared", 32'(busy), 32'h0);
    serial_in[0] = 1'b0;
    expect_evt(4'h1, 4'h0, 11);
    tick(15);
    chk("ch0_rebusy", 32'(busy), 32'h1);
    serial_in[0] = 1'b1;
    pulse_clear(4'h1);
    tick(5);

    // ch2 disabled while toggling, then disable mid-VERIFY.
    enable[2] = 1'b0;
    serial_in[2] = 1'b0; tick(2);
    serial_in[2] = 1'b1; tick(3);
    serial_in[2] = 1'b0; tick(12);
    serial_in[2] = 1'b1; tick(5);
    enable[2] = 1'b1;
    tick(3);
    serial_in[2] = 1'b0;
    tick(5);
    enable[2] = 1'b0;
    tick(1);
    enable[2] = 1'b1;
    tick(15);
    chk("ch2_no_busy", 32'(busy), 32'h0);
    serial_in[2] = 1'b1;
    tick(5);

    // half_bit_cnt = 0 acts as 1: latency 4.
    half_bit_cnt = 8'd0;
    serial_in[1] = 1'b0;
    expect_evt(4'h2, 4'h0, 4);
    tick(8);
    chk("hb0_busy", 32'(busy), 32'h2);
    serial_in[1] = 1'b1;
    pulse_clear(4'h2);
    tick(3);

    // hb=2: line returns high exactly at terminal count -> glitch wins.
    half_bit_cnt = 8'd2;
    serial_in[1] = 1'b0;
    expect_evt(4'h0, 4'h2, 5);
    tick(2);
    serial_in[1] = 1'b1;
    tick(8);
    chk("prec_idle", 32'(busy), 32'h0);
    // hb=2: one more low cycle -> validated.
    serial_in[1] = 1'b0;
    expect_evt(4'h2, 4'h0, 5);
    tick(3);
    serial_in[1] = 1'b1;
    tick(8);
    chk("hb2_busy", 32'(busy), 32'h2);
    pulse_clear(4'h2);
    half_bit_cnt = 8'd8;
    tick(3);

    // Reset 4 cycles into VERIFY with line held low.
    serial_in[3] = 1'b0;
    tick(7);
    n_rst = 1'b0;
    #1;
    chk("midrst_npd", 32'(npd), 32'h0);
    chk("midrst_fs", 32'(fs), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    tick(3);
    n_rst = 1'b1;
    tick(30);
    chk("post_rst_low_busy", 32'(busy), 32'h0);
    serial_in[3] = 1'b1;
    tick(5);
    serial_in[3] = 1'b0;
    expect_evt(4'h8, 4'h0, 11);
    tick(15);
    chk("post_rst_busy", 32'(busy), 32'h8);
    serial_in[3] = 1'b1;
    pulse_clear(4'hF);
    tick(5);

    // All four channels fall together.
    serial_in = 4'h0;
    expect_evt(4'hF, 4'h0, 11);
    tick(15);
    chk("all_busy", 32'(busy), 32'hF);
    serial_in = 4'hF;
    pulse_clear(4'hF);
    tick(5);
    chk("all_cleared", 32'(busy), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
